// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the packet-aware stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // True when a requested channel index addresses an existing channel.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output beat register {last, data} with valid/ready hold behaviour.
module stream_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [W:0] din,
  input  logic       ready,
  output logic       valid,
  output logic [W:0] dout
);

  // A load always wins; otherwise a consumed beat empties the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel packet-aware stream mux: channel switches only between packets.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  input  logic            out_ready,
  input  logic [SW-1:0]   sel_in,
  input  logic            sel_load,
  output logic [SW-1:0]   sel_cur,
  output logic            sel_err
);

  state_t        state, state_n;
  logic [SW-1:0] sel_cur_n, sel_pend, sel_pend_n;
  logic          pend, pend_n, pkt_open, pkt_open_n, sel_err_n;
  logic          slot_free, accept, acc_last, load_ok, pend_eff;
  logic [W-1:0]  ch_data [N];
  logic [W:0]    beat, beat_q;

  always_comb begin
    for (int k = 0; k < N; k++) ch_data[k] = in_data[k*W +: W];
  end

  assign slot_free = !out_valid || out_ready;
  assign accept    = (state == ACTIVE) && in_valid[sel_cur] && slot_free;
  assign acc_last  = in_last[sel_cur];
  assign load_ok   = sel_load && sel_valid(32'(sel_in), N);
  assign beat      = {acc_last, ch_data[sel_cur]};

  always_comb begin
    in_ready = '0;
    if (state == ACTIVE) in_ready[sel_cur] = slot_free;
  end

  // Next-state: a pending request is applied on a packet boundary, or at once when no packet is open.
  always_comb begin
    state_n    = state;
    sel_cur_n  = sel_cur;
    sel_pend_n = sel_pend;
    pend_n     = pend;
    pkt_open_n = pkt_open;
    pend_eff   = pend || load_ok;
    sel_err_n  = sel_load && !load_ok;
    case (state)
      IDLE: begin
        state_n = ACTIVE;
        if (pend) begin
          sel_cur_n = sel_pend;
          pend_n    = 1'b0;
        end
      end
      ACTIVE: begin
        if (accept) pkt_open_n = !acc_last;
        if (pend_eff && ((accept && acc_last) || (!pkt_open && !accept))) state_n = IDLE;
      end
    endcase
    if (load_ok) begin
      sel_pend_n = sel_in;
      pend_n     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_cur  <= '0;
      sel_pend <= '0;
      pend     <= 1'b0;
      pkt_open <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      state    <= state_n;
      sel_cur  <= sel_cur_n;
      sel_pend <= sel_pend_n;
      pend     <= pend_n;
      pkt_open <= pkt_open_n;
      sel_err  <= sel_err_n;
    end
  end

  stream_out_reg #(.W(W)) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .din   (beat),
    .ready (out_ready),
    .valid (out_valid),
    .dout  (beat_q)
  );

  assign out_last = beat_q[W];
  assign out_data = beat_q[W-1:0];

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: directed vector table, corner sequences, random scoreboard.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready, sel_load, sel_err;
  logic [7:0]  out_data;
  logic [1:0]  sel_in, sel_cur;

  logic [5:0]  e_in_valid, e_in_last, e_in_ready;
  logic [47:0] e_in_data;
  logic        e_out_valid, e_out_last, e_out_ready, e_sel_load, e_sel_err;
  logic [7:0]  e_out_data;
  logic [2:0]  e_sel_in, e_sel_cur;

  always #5 clk = ~clk;

  stream_mux_n #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel_in(sel_in), .sel_load(sel_load), .sel_cur(sel_cur), .sel_err(sel_err)
  );

  // Six channels so that out-of-range select codes are representable.
  stream_mux_n #(.N(6), .W(8)) u_err (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_data(e_in_data), .in_last(e_in_last),
    .in_ready(e_in_ready), .out_valid(e_out_valid), .out_data(e_out_data), .out_last(e_out_last),
    .out_ready(e_out_ready), .sel_in(e_sel_in), .sel_load(e_sel_load), .sel_cur(e_sel_cur),
    .sel_err(e_sel_err)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        ordy;
    logic        ld;
    logic [1:0]  sel;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic [1:0]  e_cur;
  } vec_t;

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       l;
  } beat_t;

  vec_t        tbl[$];
  beat_t       expq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned plen[4], bidx[4];
  logic [5:0]  seqn[4];
  logic [1:0]  req;
  int          last_ch = -1;
  logic        last_open = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] v, int ch, logic [7:0] dat, logic last, logic ordy,
                              logic ld, logic [1:0] sel, logic [3:0] e_rdy, logic e_ov,
                              logic [7:0] e_od, logic e_ol, logic [1:0] e_cur);
    vec_t r;
    r.v = v; r.d = {4{~dat}}; r.d[ch*8 +: 8] = dat; r.l = last ? 4'hF : 4'h0;
    r.ordy = ordy; r.ld = ld; r.sel = sel; r.e_rdy = e_rdy; r.e_ov = e_ov;
    r.e_od = e_od; r.e_ol = e_ol; r.e_cur = e_cur;
    return r;
  endfunction

  // One random (or draining) cycle checked against the channel-queue scoreboard.
  task automatic rnd_cycle(input bit drain);
    logic [3:0]  rdy, acc, lst;
    logic        ov, ol, ordy, ld;
    logic [7:0]  od;
    logic [1:0]  cur, sl;
    logic [31:0] dat;
    beat_t       b;
    if (drain) begin
      out_ready = 1'b1;
      sel_load  = 1'b0;
    end else begin
      out_ready = ($urandom_range(0, 9) < 7);
      sel_load  = ($urandom_range(0, 15) == 0);
      sel_in    = 2'($urandom_range(0, 3));
    end
    for (int k = 0; k < 4; k++) begin
      if (drain) in_valid[k] = (bidx[k] != 0);
      else if (!in_valid[k] && $urandom_range(0, 1) == 1) in_valid[k] = 1'b1;
      in_data[k*8 +: 8] = {2'(k), seqn[k]};
      in_last[k] = (bidx[k] == plen[k] - 1);
    end
    #1;
    rdy = in_ready; ov = out_valid; od = out_data; ol = out_last; ordy = out_ready;
    cur = sel_cur; dat = in_data; lst = in_last; acc = in_valid & rdy; ld = sel_load; sl = sel_in;
    chk("rnd in_ready_only_sel", 32'(rdy & ~(4'b0001 << cur)), 32'd0);
    @(posedge clk); #1;
    if (ov && ordy) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rnd out_beat actual=%0h expected=none", {ol, od});
      end else begin
        b = expq.pop_front();
        chk("rnd out_beat", 32'({ol, od}), 32'({b.l, b.d}));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) begin
        if (last_open) chk("rnd no_interleave", 32'(k), 32'(last_ch));
        b.ch = k; b.d = dat[k*8 +: 8]; b.l = lst[k];
        expq.push_back(b);
        last_ch = k; last_open = !lst[k];
        if (lst[k]) begin
          bidx[k] = 0;
          plen[k] = $urandom_range(1, 4);
        end else begin
          bidx[k]++;
        end
        seqn[k]++;
        in_valid[k] = 1'b0;
      end
    end
    if (ld) req = sl;
  endtask

  initial begin
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1; sel_in = '0; sel_load = 1'b0;
    e_in_valid = '0; e_in_data = '0; e_in_last = '0; e_out_ready = 1'b1; e_sel_in = '0; e_sel_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset sel_cur", 32'(sel_cur), 32'd0);
    chk("reset sel_err", 32'(sel_err), 32'd0);
    rst_n = 1'b1;

    //            v      ch dat    lst ordy ld sel e_rdy  ov od     ol cur
    tbl.push_back(mk(4'b0001, 0, 8'h11, 0, 1, 0, 0, 4'b0000, 0, 8'h00, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 8'h11, 0, 1, 0, 0, 4'b0001, 1, 8'h11, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 8'h22, 0, 1, 0, 0, 4'b0001, 1, 8'h22, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 8'h33, 1, 1, 0, 0, 4'b0001, 1, 8'h33, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 8'h00, 0, 1, 0, 0, 4'b0001, 0, 8'h00, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 8'hA1, 0, 1, 0, 0, 4'b0001, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 8'hA2, 0, 1, 1, 2, 4'b0001, 1, 8'hA2, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 8'hA3, 0, 1, 0, 0, 4'b0001, 1, 8'hA3, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 8'hA4, 1, 1, 0, 0, 4'b0001, 1, 8'hA4, 1, 0));
    tbl.push_back(mk(4'b0101, 2, 8'hA0, 0, 1, 0, 0, 4'b0000, 0, 8'h00, 0, 2));
    tbl.push_back(mk(4'b0111, 2, 8'hA0, 0, 1, 0, 0, 4'b0100, 1, 8'hA0, 0, 2));
    tbl.push_back(mk(4'b0100, 2, 8'h5A, 0, 1, 0, 0, 4'b0100, 1, 8'h5A, 0, 2));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'b0100, 2, 8'h5B, 1, 0, 0, 0, 4'b0000, 1, 8'h5A, 0, 2));
    tbl.push_back(mk(4'b0100, 2, 8'h5B, 1, 1, 0, 0, 4'b0100, 1, 8'h5B, 1, 2));
    tbl.push_back(mk(4'b0000, 2, 8'h00, 0, 1, 0, 0, 4'b0100, 0, 8'h00, 0, 2));
    tbl.push_back(mk(4'b0100, 2, 8'hC1, 0, 1, 1, 1, 4'b0100, 1, 8'hC1, 0, 2));
    tbl.push_back(mk(4'b0100, 2, 8'hC2, 0, 1, 1, 3, 4'b0100, 1, 8'hC2, 0, 2));
    tbl.push_back(mk(4'b0100, 2, 8'hC3, 1, 1, 0, 0, 4'b0100, 1, 8'hC3, 1, 2));
    tbl.push_back(mk(4'b1111, 3, 8'hD0, 1, 1, 0, 0, 4'b0000, 0, 8'h00, 0, 3));
    tbl.push_back(mk(4'b1111, 3, 8'hD0, 1, 1, 0, 0, 4'b1000, 1, 8'hD0, 1, 3));
    tbl.push_back(mk(4'b1000, 3, 8'hD1, 1, 1, 1, 1, 4'b1000, 1, 8'hD1, 1, 3));
    tbl.push_back(mk(4'b0010, 1, 8'hE0, 1, 1, 0, 0, 4'b0000, 0, 8'h00, 0, 1));
    tbl.push_back(mk(4'b0010, 1, 8'hE0, 1, 1, 0, 0, 4'b0010, 1, 8'hE0, 1, 1));
    tbl.push_back(mk(4'b0000, 1, 8'h00, 0, 1, 0, 0, 4'b0010, 0, 8'h00, 0, 1));
    tbl.push_back(mk(4'b0000, 1, 8'h00, 0, 1, 1, 3, 4'b0010, 0, 8'h00, 0, 1));
    tbl.push_back(mk(4'b0000, 3, 8'h00, 0, 1, 0, 0, 4'b0000, 0, 8'h00, 0, 3));
    tbl.push_back(mk(4'b1000, 3, 8'hF0, 0, 1, 0, 0, 4'b1000, 1, 8'hF0, 0, 3));

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
      out_ready = tbl[i].ordy; sel_load = tbl[i].ld; sel_in = tbl[i].sel;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].e_od));
        chk($sformatf("row%0d out_last", i), 32'(out_last), 32'(tbl[i].e_ol));
      end
      chk($sformatf("row%0d sel_cur", i), 32'(sel_cur), 32'(tbl[i].e_cur));
      chk($sformatf("row%0d sel_err", i), 32'(sel_err), 32'd0);
    end

    // Asynchronous reset while a beat sits in the output register.
    out_ready = 1'b0; in_valid = '0; sel_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid sel_cur", 32'(sel_cur), 32'd0);
    chk("rst_mid in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Select load in the first cycle out of reset reaches the new channel three cycles later.
    sel_in = 2'd2; sel_load = 1'b1; in_valid = 4'b0100; in_data = 32'h8888_7788;
    in_data[23:16] = 8'h77; in_last = 4'hF; out_ready = 1'b1;
    #1;
    chk("post_rst c0 in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    sel_load = 1'b0;
    chk("post_rst c1 out_valid", 32'(out_valid), 32'd0);
    chk("post_rst c1 in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post_rst c2 in_ready", 32'(in_ready), 32'd0);
    chk("post_rst c2 sel_cur", 32'(sel_cur), 32'd0);
    @(posedge clk); #1;
    chk("post_rst c3 in_ready", 32'(in_ready), 32'b0100);
    chk("post_rst c3 sel_cur", 32'(sel_cur), 32'd2);
    @(posedge clk); #1;
    chk("post_rst out_valid", 32'(out_valid), 32'd1);
    chk("post_rst out_data", 32'(out_data), 32'h77);
    chk("post_rst out_last", 32'(out_last), 32'd1);
    in_valid = '0;
    @(posedge clk); #1;

    // Out-of-range select on the six-channel instance.
    e_sel_in = 3'd6; e_sel_load = 1'b1;
    @(posedge clk); #1;
    e_sel_load = 1'b0;
    chk("err pulse", 32'(e_sel_err), 32'd1);
    @(posedge clk); #1;
    chk("err one_cycle", 32'(e_sel_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("err sel_unchanged", 32'(e_sel_cur), 32'd0);
    chk("err out_valid", 32'(e_out_valid), 32'd0);
    e_sel_in = 3'd5; e_sel_load = 1'b1;
    @(posedge clk); #1;
    e_sel_load = 1'b0;
    chk("err valid_load_no_pulse", 32'(e_sel_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("err sel_applied", 32'(e_sel_cur), 32'd5);
    chk("err in_ready", 32'(e_in_ready), 32'b100000);

    // Random traffic against per-channel packet queues.
    req = 2'd2;
    for (int k = 0; k < 4; k++) begin
      plen[k] = $urandom_range(1, 4);
      bidx[k] = 0;
      seqn[k] = '0;
    end
    in_valid = '0;
    for (int c = 0; c < 3000; c++) rnd_cycle(1'b0);
    for (int c = 0; c < 40; c++) rnd_cycle(1'b1);
    chk("rnd drained", 32'(expq.size()), 32'd0);
    chk("rnd final_sel", 32'(sel_cur), 32'(req));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
